// File: rtl/wb_commit.sv
// -----------------------------------------------------------------------------
// wb_commit
// Write-back commit stage at the far end of the MEM/WB pipeline register.
// It commits the architectural state carried by the wb_* bundle: the 32x32
// general register file, the HI/LO pair and the LLbit. It also serves two
// GPR read ports to decode, and these ports bypass the write being committed
// in the same cycle.
//
// Ports
//   clk, rst                   clock; asynchronous active-low reset
//   wb_waddr/wb_we/wb_wdata    GPR write (writes to r0 are discarded)
//   wb_whilo/wb_hi/wb_lo       HI/LO pair write (always written together)
//   wb_LLbit_we/wb_LLbit_value LLbit write
//   flush                      exception flush, clears the LLbit only
//   re1/raddr1 -> rdata1       combinational read port 1 (bypassed)
//   re2/raddr2 -> rdata2       combinational read port 2 (bypassed)
//   hi_o, lo_o, LLbit_o        committed HI/LO/LLbit (registered, no bypass)
// -----------------------------------------------------------------------------
module wb_commit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_waddr,
  input  logic        wb_we,
  input  logic [31:0] wb_wdata,
  input  logic        wb_whilo,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic        wb_LLbit_we,
  input  logic        wb_LLbit_value,
  input  logic        flush,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        LLbit_o
);

  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        llbit_q, llbit_d;

  // Next-state for all committed state. The GPR, HI/LO and LLbit updates are
  // independent; flush only touches the LLbit.
  always_comb begin
    gpr_d = gpr_q;
    if (wb_we && (wb_waddr != 5'd0)) begin
      gpr_d[wb_waddr] = wb_wdata;
    end

    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_whilo) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end

    llbit_d = llbit_q;
    if (flush) begin
      llbit_d = 1'b0;
    end else if (wb_LLbit_we) begin
      llbit_d = wb_LLbit_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q    <= '0;
      lo_q    <= '0;
      llbit_q <= 1'b0;
    end else begin
      gpr_q   <= gpr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      llbit_q <= llbit_d;
    end
  end

  // Read ports: r0 is tested before the bypass so that a discarded write to
  // r0 can never leak onto a read of r0.
  assign rdata1 = (!rst || !re1 || (raddr1 == 5'd0)) ? 32'd0 :
                  (wb_we && (raddr1 == wb_waddr))    ? wb_wdata :
                                                       gpr_q[raddr1];
  assign rdata2 = (!rst || !re2 || (raddr2 == 5'd0)) ? 32'd0 :
                  (wb_we && (raddr2 == wb_waddr))    ? wb_wdata :
                                                       gpr_q[raddr2];

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign LLbit_o = llbit_q;

endmodule

// File: tb/tb_wb_commit.sv
// -----------------------------------------------------------------------------
// tb_wb_commit
// Bench for wb_commit. A driver applies one stimulus vector per cycle just
// after the rising edge, pushes the expected outputs for that cycle into a
// scoreboard queue, and advances a behavioural model of the architectural
// state on the edge. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_wb_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_LLbit_we;
  logic        wb_LLbit_value;
  logic        flush;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        LLbit_o;

  wb_commit dut (
    .clk(clk), .rst(rst),
    .wb_waddr(wb_waddr), .wb_we(wb_we), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
    .flush(flush),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ll;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model of the architectural state.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_ll;

  function automatic logic [31:0] m_read(input logic e, input logic [4:0] a);
    if (!rst || !e || a == 5'd0) return 32'd0;
    if (wb_we && a == wb_waddr)  return wb_wdata;
    return m_gpr[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    m_ll = 1'b0;
  endtask

  task automatic chk(input string tag, input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", tag, nm, got, exp);
    end
  endtask

  // Monitor: compares the DUT against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, "rdata1", rdata1, e.r1);
      chk(e.tag, "rdata2", rdata2, e.r2);
      chk(e.tag, "hi_o", hi_o, e.hi);
      chk(e.tag, "lo_o", lo_o, e.lo);
      chk(e.tag, "LLbit_o", {31'd0, LLbit_o}, {31'd0, e.ll});
    end
  end

  task automatic clr();
    rst = 1'b1; wb_waddr = '0; wb_we = 1'b0; wb_wdata = '0;
    wb_whilo = 1'b0; wb_hi = '0; wb_lo = '0;
    wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; flush = 1'b0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
  endtask

  // Applies the currently driven vector for one cycle. Called #1 after a
  // rising edge; returns #1 after the next rising edge.
  task automatic step(input string tag);
    exp_t e;
    #0;
    if (!rst) model_clear();
    e.tag = tag;
    e.r1  = m_read(re1, raddr1);
    e.r2  = m_read(re2, raddr2);
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.ll  = m_ll;
    sb.push_back(e);
    @(posedge clk);
    if (rst) begin
      if (wb_we && wb_waddr != 5'd0) m_gpr[wb_waddr] = wb_wdata;
      if (wb_whilo) begin
        m_hi = wb_hi;
        m_lo = wb_lo;
      end
      if (flush)            m_ll = 1'b0;
      else if (wb_LLbit_we) m_ll = wb_LLbit_value;
    end
    #1;
  endtask

  initial begin
    clr();
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;

    // Reset state
    rst = 1'b0; re1 = 1'b1; raddr1 = 5'd5; step("reset_a");
    step("reset_b");

    // Populate, then assert reset mid-cycle with no edge before the check
    clr(); wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h1234;
    wb_whilo = 1'b1; wb_hi = 32'hA; wb_lo = 32'hB;
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1; step("pre_reset_wr");
    clr(); re1 = 1'b1; raddr1 = 5'd5; step("pre_reset_rd");
    clr(); rst = 1'b0; re1 = 1'b1; raddr1 = 5'd5; step("async_reset");
    clr(); re1 = 1'b1; raddr1 = 5'd5; step("post_reset_rd");

    // Write/read and r0
    clr(); wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hDEADBEEF; step("wr_r7");
    clr(); re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7; step("rd_r7");
    clr(); wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFFFFFF;
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0; step("wr_r0");
    clr(); re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0; step("rd_r0");

    // Bypass
    clr(); wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h11; step("wr_r3");
    clr(); wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h55AA55AA;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b0; raddr2 = 5'd3; step("bypass_r3");
    clr(); re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3; step("rd_r3");
    clr(); wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h77;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3; step("bypass_both");

    // HI/LO
    clr(); wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2; step("hilo_wr");
    clr(); wb_hi = 32'hFF; wb_lo = 32'hEE; step("hilo_hold");
    step("hilo_hold2");

    // LLbit priority and flush independence
    clr(); wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1; step("ll_set");
    clr(); flush = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h9; step("ll_flush");
    clr(); re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd9; step("rd_r9");

    // Concurrent update
    clr(); wb_we = 1'b1; wb_waddr = 5'd31; wb_wdata = 32'h80000000;
    wb_whilo = 1'b1; wb_hi = 32'hC; wb_lo = 32'hD;
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1; step("concurrent");
    clr(); re1 = 1'b1; raddr1 = 5'd31; step("rd_r31");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 79) != 0);
      wb_waddr       = 5'($urandom_range(0, 31));
      wb_we          = 1'($urandom_range(0, 1));
      wb_wdata       = $urandom;
      wb_whilo       = ($urandom_range(0, 3) == 0);
      wb_hi          = $urandom;
      wb_lo          = $urandom;
      wb_LLbit_we    = 1'($urandom_range(0, 1));
      wb_LLbit_value = 1'($urandom_range(0, 1));
      flush          = ($urandom_range(0, 7) == 0);
      re1            = ($urandom_range(0, 7) != 0);
      re2            = ($urandom_range(0, 7) != 0);
      raddr1         = ($urandom_range(0, 3) == 0) ? wb_waddr : 5'($urandom_range(0, 31));
      raddr2         = ($urandom_range(0, 3) == 0) ? wb_waddr : 5'($urandom_range(0, 31));
      step("random");
    end
    clr();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
